// File: rtl/updown_wrap_monitor.sv
// updown_wrap_monitor: checks every step of a 4-bit up/down counter and flags wraps and illegal steps.
// Latency: one edge from a sample to any output change; all outputs are registered.
// Backpressure: none. The block is a passive observer and samples on every clock edge.
//
// Ports:
//   clk       rising-edge clock, shared with the monitored counter
//   rst_n     asynchronous active-low reset
//   cnt_rst   copy of the counter's own reset (1 = counter value not meaningful)
//   ud        direction applied to the counter (1 = up, 0 = down)
//   counter   4-bit counter value being monitored
//   clr       synchronous clear of ovf_cnt, unf_cnt and step_err
//   valid     a previous sample is held and step checking is active
//   ovf/unf   one-cycle pulses on a 15->0 up-wrap / 0->15 down-wrap
//   ovf_cnt   8-bit overflow count
//   unf_cnt   8-bit underflow count
//   step_err  sticky flag for an illegal counter step
//
// Build option: define UPDOWN_WRAP_MON_SAT_EN to make ovf_cnt/unf_cnt saturate at 255.
// By default they wrap from 255 to 0.

module updown_wrap_monitor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cnt_rst,
  input  logic       ud,
  input  logic [3:0] counter,
  input  logic       clr,
  output logic       valid,
  output logic       ovf,
  output logic       unf,
  output logic [7:0] ovf_cnt,
  output logic [7:0] unf_cnt,
  output logic       step_err
);

  logic [3:0] r_prev_cnt;
  logic       r_prev_ud;
  logic       r_valid;
  logic       r_ovf;
  logic       r_unf;
  logic [7:0] r_ovf_cnt;
  logic [7:0] r_unf_cnt;
  logic       r_step_err;

  logic       w_check;
  logic [3:0] w_exp_cnt;
  logic       w_legal;
  logic       w_illegal;
  logic       w_ovf_evt;
  logic       w_unf_evt;
  logic [7:0] w_ovf_base;
  logic [7:0] w_unf_base;
  logic [7:0] w_ovf_cnt_nxt;
  logic [7:0] w_unf_cnt_nxt;
  logic       w_step_err_nxt;

  // A step is only judged when the previous sample is meaningful.
  // The counter must also be out of its own reset on this edge.
  assign w_check   = r_valid & ~cnt_rst;

  // The step is judged against the direction that was applied when the previous sample was taken.
  // A ud reversal therefore shows up one step later.
  assign w_exp_cnt = r_prev_ud ? (r_prev_cnt + 4'd1) : (r_prev_cnt - 4'd1);
  assign w_legal   = (counter == w_exp_cnt);
  assign w_illegal = w_check & ~w_legal;

  // Only a legal step can be a wrap: w_legal already forces counter to 0 or 15.
  assign w_ovf_evt = w_check & w_legal &  r_prev_ud & (r_prev_cnt == 4'hF);
  assign w_unf_evt = w_check & w_legal & ~r_prev_ud & (r_prev_cnt == 4'h0);

  // A clear takes effect before an event on the same edge.
  // That edge therefore ends with a count of 1 and/or step_err set.
  assign w_ovf_base = clr ? 8'd0 : r_ovf_cnt;
  assign w_unf_base = clr ? 8'd0 : r_unf_cnt;

  always_comb begin
    w_ovf_cnt_nxt = w_ovf_base;
    w_unf_cnt_nxt = w_unf_base;
`ifdef UPDOWN_WRAP_MON_SAT_EN
    if (w_ovf_evt && (w_ovf_base != 8'hFF)) w_ovf_cnt_nxt = w_ovf_base + 8'd1;
    if (w_unf_evt && (w_unf_base != 8'hFF)) w_unf_cnt_nxt = w_unf_base + 8'd1;
`else
    if (w_ovf_evt) w_ovf_cnt_nxt = w_ovf_base + 8'd1;
    if (w_unf_evt) w_unf_cnt_nxt = w_unf_base + 8'd1;
`endif
  end

  assign w_step_err_nxt = (clr ? 1'b0 : r_step_err) | w_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_cnt <= 4'd0;
      r_prev_ud  <= 1'b0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_ovf_cnt  <= 8'd0;
      r_unf_cnt  <= 8'd0;
      r_step_err <= 1'b0;
    end else begin
      r_prev_cnt <= counter;
      r_prev_ud  <= ud;
      r_valid    <= ~cnt_rst;
      r_ovf      <= w_ovf_evt;
      r_unf      <= w_unf_evt;
      r_ovf_cnt  <= w_ovf_cnt_nxt;
      r_unf_cnt  <= w_unf_cnt_nxt;
      r_step_err <= w_step_err_nxt;
    end
  end

  assign valid    = r_valid;
  assign ovf      = r_ovf;
  assign unf      = r_unf;
  assign ovf_cnt  = r_ovf_cnt;
  assign unf_cnt  = r_unf_cnt;
  assign step_err = r_step_err;

endmodule

// File: tb/tb_updown_wrap_monitor.sv
// tb_updown_wrap_monitor: directed-vector bench for updown_wrap_monitor.
// Latency: outputs are compared 1 time unit after the edge that produced them.
// Backpressure: not applicable.

module tb_updown_wrap_monitor;

  logic       clk;
  logic       rst_n;
  logic       cnt_rst;
  logic       ud;
  logic [3:0] counter;
  logic       clr;
  logic       valid;
  logic       ovf;
  logic       unf;
  logic [7:0] ovf_cnt;
  logic [7:0] unf_cnt;
  logic       step_err;

  updown_wrap_monitor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt_rst  (cnt_rst),
    .ud       (ud),
    .counter  (counter),
    .clr      (clr),
    .valid    (valid),
    .ovf      (ovf),
    .unf      (unf),
    .ovf_cnt  (ovf_cnt),
    .unf_cnt  (unf_cnt),
    .step_err (step_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cr;
    logic       ud;
    logic [3:0] cnt;
    logic       clr;
    logic       v;
    logic       o;
    logic       u;
    logic [7:0] oc;
    logic [7:0] uc;
    logic       e;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void add(input logic cr, input logic d, input logic [3:0] c, input logic cl,
                              input logic v, input logic o, input logic u,
                              input logic [7:0] oc, input logic [7:0] uc, input logic e);
    vec_t r;
    r.cr = cr; r.ud = d; r.cnt = c; r.clr = cl;
    r.v = v; r.o = o; r.u = u; r.oc = oc; r.uc = uc; r.e = e;
    vecs.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Drive one sample, clock it, and settle just after the edge.
  task automatic step(input logic cr, input logic d, input logic [3:0] c, input logic cl);
    cnt_rst = cr; ud = d; counter = c; clr = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cnt_rst = 1'b1; ud = 1'b0; counter = 4'd0; clr = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic o, input logic u,
                         input logic [7:0] oc, input logic [7:0] uc, input logic e);
    chk({tag, " valid"},    {7'd0, valid},    {7'd0, v});
    chk({tag, " ovf"},      {7'd0, ovf},      {7'd0, o});
    chk({tag, " unf"},      {7'd0, unf},      {7'd0, u});
    chk({tag, " ovf_cnt"},  ovf_cnt,          oc);
    chk({tag, " unf_cnt"},  unf_cnt,          uc);
    chk({tag, " step_err"}, {7'd0, step_err}, {7'd0, e});
  endtask

  initial begin
    int         pulses;
    logic [3:0] c;
    logic [7:0] exp_sat;

    // ---------------- vector table ----------------
    // The first sample is held under the counter's reset.
    add(1,1,0,0, 0,0,0,0,0,0);
    // The first edge out of cnt_rst only captures; 0..15 counting up is legal.
    for (int i = 0; i < 16; i++) begin
      c = 4'(i);
      add(0,1,c,0, 1,0,0,0,0,0);
    end
    add(0,1,0,0, 1,1,0,1,0,0);   // 15->0 overflow pulse
    add(0,1,1,0, 1,0,0,1,0,0);   // pulse lasts one cycle
    add(0,1,2,0, 1,0,0,1,0,0);
    add(0,1,3,0, 1,0,0,1,0,0);
    add(0,1,4,0, 1,0,0,1,0,0);
    add(0,0,5,0, 1,0,0,1,0,0);   // ud flips here; 4->5 is still judged as an up step
    add(0,0,4,0, 1,0,0,1,0,0);
    add(0,0,3,0, 1,0,0,1,0,0);
    add(0,0,2,0, 1,0,0,1,0,0);
    add(0,0,1,0, 1,0,0,1,0,0);
    add(0,0,0,0, 1,0,0,1,0,0);
    add(0,0,15,0, 1,0,1,1,1,0);  // 0->15 underflow pulse
    add(0,0,14,0, 1,0,0,1,1,0);
    add(1,0,9,0, 0,0,0,1,1,0);   // a jump under cnt_rst is not judged
    add(0,0,13,0, 1,0,0,1,1,0);  // the first edge after cnt_rst only captures
    for (int i = 12; i >= 7; i--) begin
      c = 4'(i);
      add(0,0,c,0, 1,0,0,1,1,0);
    end
    add(0,0,7,0, 1,0,0,1,1,1);   // holding at 7 is illegal
    add(0,0,6,0, 1,0,0,1,1,1);   // step_err is sticky
    add(0,0,5,1, 1,0,0,0,0,0);   // clr wipes the counts and the flag
    add(0,0,4,0, 1,0,0,0,0,0);
    add(0,0,4,1, 1,0,0,0,0,1);   // clr with an illegal step on the same edge
    add(0,0,3,1, 1,0,0,0,0,0);

    do_reset();
    #1;
    chk_all("reset", 0,0,0,8'd0,8'd0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].cr, vecs[i].ud, vecs[i].cnt, vecs[i].clr);
      chk_all($sformatf("row%0d", i), vecs[i].v, vecs[i].o, vecs[i].u,
              vecs[i].oc, vecs[i].uc, vecs[i].e);
    end

    // ---------------- clr on the same edge as an overflow ----------------
    do_reset();
    step(1,1,0,0);
    for (int k = 0; k <= 144; k++) begin
      c = 4'(k);
      step(0,1,c,0);
    end
    chk("nine_ovf ovf_cnt", ovf_cnt, 8'd9);
    for (int k = 1; k <= 15; k++) begin
      c = 4'(k);
      step(0,1,c,0);
    end
    step(0,1,0,1);
    chk_all("clr_ovf", 1,1,0,8'd1,8'd0,0);

    // ---------------- reset asserted between edges ----------------
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0,0,0,8'd0,8'd0,0);

    // ---------------- 256 overflows ----------------
    do_reset();
    step(1,1,0,0);
    pulses = 0;
    for (int k = 0; k <= 4096; k++) begin
      c = 4'(k);
      step(0,1,c,0);
      if (ovf) pulses++;
      if (k == 255 * 16) chk("ovf_cnt_at_255", ovf_cnt, 8'd255);
    end
`ifdef UPDOWN_WRAP_MON_SAT_EN
    exp_sat = 8'd255;
`else
    exp_sat = 8'd0;
`endif
    chk("ovf_cnt_after_256", ovf_cnt, exp_sat);
    chk("ovf_pulses_256", 8'(pulses), 8'd0);
    chk("ovf_pulse_last", {7'd0, ovf}, 8'd1);
    chk("err_after_256", {7'd0, step_err}, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/updown_wrap_monitor.md
UPDOWN_WRAP_MONITOR -- requirements
Module: updown_wrap_monitor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed below, clock and reset first.
REQ-002 clk  input  1  rising-edge clock, shared with the up/down counter.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cnt_rst  input  1  copy of the counter's own reset; high means the counter value is not meaningful.
REQ-005 ud  input  1  direction applied to the counter (1 = up, 0 = down).
REQ-006 counter  input  4  counter output being monitored.
REQ-007 clr  input  1  synchronous clear of the event counts and the error flag.
REQ-008 valid  output  1  high when a previous sample is held and step checking is active.
REQ-009 ovf  output  1  one-cycle pulse on an up-wrap from 15 to 0.
REQ-010 unf  output  1  one-cycle pulse on a down-wrap from 0 to 15.
REQ-011 ovf_cnt  output  8  number of overflows seen.
REQ-012 unf_cnt  output  8  number of underflows seen.
REQ-013 step_err  output  1  sticky flag for an illegal counter step.

Function
REQ-014 At each rising clk edge, the block SHALL register counter into prev_cnt and ud into prev_ud.
REQ-015 valid SHALL be 0 while cnt_rst=1 and SHALL become 1 at the first edge where cnt_rst=0.
- Sample n is therefore checked against sample n-1 starting from the second edge.
REQ-016 When valid=1 and cnt_rst=0, each edge SHALL classify the step from prev_cnt to counter using prev_ud:
- legal: (prev_cnt+1) mod 16 if prev_ud=1, or (prev_cnt-1) mod 16 if prev_ud=0;
- anything else is illegal, including no change.
REQ-017 ovf SHALL be 1 for exactly the cycle after an edge where prev_ud=1, prev_cnt=15 and counter=0; otherwise ovf SHALL be 0.
REQ-018 unf SHALL be 1 for exactly the cycle after an edge where prev_ud=0, prev_cnt=0 and counter=15; otherwise unf SHALL be 0.
REQ-019 Each ovf pulse SHALL increment ovf_cnt by 1 on the same edge, and each unf pulse SHALL increment unf_cnt by 1 on the same edge.
REQ-020 An illegal step SHALL set step_err at that edge; step_err SHALL stay set until clr or rst_n.
- An illegal step SHALL produce no ovf or unf pulse.
REQ-021 Direction change: a reversal applies from the next step; the first step after a ud toggle is checked against the new prev_ud.
REQ-022 Any edge with cnt_rst=1 SHALL clear valid, suppress classification, and leave ovf_cnt, unf_cnt and step_err unchanged.
REQ-023 clr=1 SHALL zero ovf_cnt, unf_cnt and step_err; clr SHALL have no effect on valid, prev_cnt or prev_ud.
REQ-024 clr together with an event on the same edge SHALL apply the clear first, then the event.
- The result is a count of 1 and/or step_err=1.
REQ-025 Latency from the sampling edge to any output change SHALL be one edge; all outputs SHALL be registered.

Reset
REQ-026 While rst_n=0, asynchronously: valid=0, ovf=0, unf=0, ovf_cnt=0, unf_cnt=0, step_err=0, prev_cnt=0, prev_ud=0.
REQ-027 After rst_n deasserts, the first edge SHALL only capture the sample; no check is made until valid=1.
REQ-028 Reset asserted mid-operation SHALL take effect immediately, independent of clk.

Configuration
REQ-029 Macro UPDOWN_WRAP_MON_SAT_EN SHALL select how ovf_cnt and unf_cnt behave at 255:
- defined: both counts saturate at 255 and further events leave them at 255; pulses still occur.
- undefined: both counts wrap from 255 to 0.

Verification
REQ-030 rst_n=0, then 1, with cnt_rst=1 for 1 cycle, then ud=1 for 16 counts from 0 -> ovf=1 for exactly one cycle after 15->0, ovf_cnt=1, unf_cnt=0, step_err=0.
REQ-031 From counter=3, ud=0, counting down through 0 to 15 -> unf pulse once, unf_cnt=1, no ovf.
REQ-032 Hold counter at 7 for one edge with valid=1 -> step_err=1 from the next cycle; it stays 1 until a clr pulse sets it to 0.
REQ-033 Drive 256 overflows -> with UPDOWN_WRAP_MON_SAT_EN, ovf_cnt=255; without it, ovf_cnt=0.
REQ-034 clr=1 on the same edge as an overflow with ovf_cnt=9 -> ovf_cnt=1.
- Then rst_n=0 mid-count -> all outputs 0 immediately.
REQ-035 ud toggles 1->0 at counter=5, giving sequence 4,5,4,3 -> no step_err, no pulses.
